// File: rtl/audio_vad_framer.sv
// audio_vad_framer: pops stereo samples from the ADC FIFO, down-mixes them to
// signed 16-bit mono, accumulates mean-square energy over fixed-length frames
// and drives a voice-activity flag with a hangover.
module audio_vad_framer #(
  parameter int unsigned LOG2_FRAME  = 8,
  parameter int unsigned HANG_FRAMES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        fifo_empty,
  output logic        fifo_rd,
  input  logic [31:0] fifo_data,
  input  logic [31:0] threshold,
  output logic [15:0] mono_data,
  output logic        mono_valid,
  output logic [31:0] frame_energy,
  output logic        frame_done,
  output logic        vad
);

  localparam int unsigned ACC_W  = 31 + LOG2_FRAME;
  localparam int unsigned HANG_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    ACC,
    DONE
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [ACC_W-1:0]        acc_q;
  logic [LOG2_FRAME-1:0]   sample_cnt_q;
  logic [HANG_W-1:0]       hang_q;

  logic signed [16:0]      mix_sum;
  logic [15:0]             mix_mono;
  logic [15:0]             mono_mag;
  logic [30:0]             mag_ext;
  logic [30:0]             sq;
  logic [ACC_W-1:0]        acc_sum;
  logic [31:0]             energy;
  logic                    last_sample;

  // Down-mix: sign-extended sum, arithmetic halving (rounds toward -inf)
  assign mix_sum  = {fifo_data[31], fifo_data[31:16]} + {fifo_data[15], fifo_data[15:0]};
  assign mix_mono = 16'(mix_sum >>> 1);

  // Square via magnitude; -32768 maps to 0x8000 which is still exact unsigned
  assign mono_mag = mono_data[15] ? 16'(-mono_data) : mono_data;
  assign mag_ext  = 31'(mono_mag);
  assign sq       = mag_ext * mag_ext;

  assign acc_sum     = acc_q + ACC_W'(sq);
  assign energy      = 32'(acc_sum >> LOG2_FRAME);
  assign last_sample = &sample_cnt_q;

  // Pop strobe is a pure decode of the RD state
  assign fifo_rd = (state_q == RD);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; enable and fifo_empty only matter in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable && !fifo_empty) state_d = RD;
      RD:      state_d = WAIT;
      WAIT:    state_d = ACC;
      ACC:     state_d = last_sample ? DONE : IDLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: mono is loaded leaving WAIT so it is visible during ACC;
  // frame results are loaded leaving ACC so they are visible during DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q        <= '0;
      sample_cnt_q <= '0;
      hang_q       <= '0;
      mono_data    <= '0;
      mono_valid   <= 1'b0;
      frame_energy <= '0;
      frame_done   <= 1'b0;
      vad          <= 1'b0;
    end else begin
      mono_valid <= 1'b0;
      frame_done <= 1'b0;
      case (state_q)
        WAIT: begin
          mono_data  <= mix_mono;
          mono_valid <= 1'b1;
        end
        ACC: begin
          if (last_sample) begin
            acc_q        <= '0;
            sample_cnt_q <= '0;
            frame_energy <= energy;
            frame_done   <= 1'b1;
            if (energy > threshold) begin
              vad    <= 1'b1;
              hang_q <= HANG_W'(HANG_FRAMES);
            end else if (hang_q != '0) begin
              hang_q <= hang_q - HANG_W'(1);
            end else begin
              vad <= 1'b0;
            end
          end else begin
            acc_q        <= acc_sum;
            sample_cnt_q <= sample_cnt_q + LOG2_FRAME'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_vad_framer.sv
// Testbench for audio_vad_framer: FIFO model, down-mix/energy/VAD reference
// model and directed frame scenarios.
module tb_audio_vad_framer;

  localparam int unsigned LOG2_FRAME  = 8;
  localparam int unsigned HANG_FRAMES = 4;
  localparam int unsigned FRAME_LEN   = 1 << LOG2_FRAME;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        fifo_empty;
  logic        fifo_rd;
  logic [31:0] fifo_data;
  logic [31:0] threshold;
  logic [15:0] mono_data;
  logic        mono_valid;
  logic [31:0] frame_energy;
  logic        frame_done;
  logic        vad;

  int ncomp = 0;
  int nfail = 0;

  bit          rand_mode = 0;
  logic [31:0] fifo_q[$];
  logic [15:0] exp_mono[$];
  longint      rd_cyc[$];
  logic [31:0] exp_e[$];
  bit          exp_v[$];
  longint      cyc = 0;
  longint      last_rd = -100;
  longint      last_mono = -100;
  longint      e_acc = 0;
  int          m_cnt = 0;
  bit          m_vad = 0;
  int          m_hang = 0;
  int          mono_seen = 0;
  int          frames_seen = 0;

  audio_vad_framer #(.LOG2_FRAME(LOG2_FRAME), .HANG_FRAMES(HANG_FRAMES)) dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd(fifo_rd), .fifo_data(fifo_data), .threshold(threshold),
    .mono_data(mono_data), .mono_valid(mono_valid), .frame_energy(frame_energy),
    .frame_done(frame_done), .vad(vad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Floor of the average of the two signed channels
  function automatic logic [15:0] ref_mix(input logic [31:0] w);
    logic [15:0] lh, rh;
    int l, r, s, m;
    lh = w[31:16];
    rh = w[15:0];
    l = int'(signed'(lh));
    r = int'(signed'(rh));
    s = l + r;
    m = (s >= 0) ? s / 2 : -((1 - s) / 2);
    return 16'(m);
  endfunction

  // Monitor, FIFO model and reference model, all at the falling edge
  always @(negedge clk) begin
    logic [31:0] w;
    int          mv;
    longint      e;
    if (!reset) begin
      if (fifo_rd) begin
        chk("rd_gate", {31'b0, fifo_empty === 1'b0 && enable === 1'b1}, 32'd1);
        chk("rd_spacing", {31'b0, (cyc - last_rd) >= 4}, 32'd1);
        last_rd = cyc;
        if (fifo_q.size() == 0) begin
          chk("rd_nonempty", 32'(fifo_q.size()), 32'd1);
        end else begin
          w = fifo_q.pop_front();
          fifo_data = w;
          exp_mono.push_back(ref_mix(w));
          rd_cyc.push_back(cyc);
        end
      end
      if (mono_valid) begin
        if (exp_mono.size() == 0) begin
          chk("mono_spurious", 32'(exp_mono.size()), 32'd1);
        end else begin
          chk("mono_data", {16'b0, mono_data}, {16'b0, exp_mono.pop_front()});
          chk("mono_latency", 32'(cyc - rd_cyc.pop_front()), 32'd2);
        end
        mv = int'(signed'(mono_data));
        e_acc += longint'(mv * mv);
        m_cnt++;
        mono_seen++;
        last_mono = cyc;
        if (m_cnt == FRAME_LEN) begin
          e = e_acc / FRAME_LEN;
          if (e > longint'(threshold)) begin
            m_vad  = 1;
            m_hang = HANG_FRAMES;
          end else if (m_hang > 0) begin
            m_hang--;
          end else begin
            m_vad = 0;
          end
          exp_e.push_back(32'(e));
          exp_v.push_back(m_vad);
          e_acc = 0;
          m_cnt = 0;
        end
      end
      if (frame_done) begin
        frames_seen++;
        chk("frame_timing", 32'(cyc - last_mono), 32'd1);
        if (exp_e.size() == 0) begin
          chk("frame_spurious", 32'(exp_e.size()), 32'd1);
        end else begin
          chk("frame_energy", frame_energy, exp_e.pop_front());
          chk("frame_vad", {31'b0, vad}, {31'b0, exp_v.pop_front()});
        end
      end
    end
    fifo_empty = (fifo_q.size() == 0) || (rand_mode && ($urandom_range(0, 2) == 0));
    enable     = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  task automatic push_frame(input logic [31:0] w);
    repeat (FRAME_LEN) fifo_q.push_back(w);
  endtask

  task automatic push_rand(input int n);
    repeat (n) fifo_q.push_back($urandom);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int k = 0;
    while (frames_seen < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    #1;
    chk("frame_wait", {31'b0, frames_seen >= target}, 32'd1);
  endtask

  task automatic run_frame(input logic [31:0] w, input bit exp_vad, input string tag);
    push_frame(w);
    wait_frames(frames_seen + 1, 2000);
    chk(tag, {31'b0, vad}, {31'b0, exp_vad});
  endtask

  task automatic chk_outputs_zero();
    chk("rst_fifo_rd", {31'b0, fifo_rd}, 32'd0);
    chk("rst_mono_data", {16'b0, mono_data}, 32'd0);
    chk("rst_mono_valid", {31'b0, mono_valid}, 32'd0);
    chk("rst_frame_energy", frame_energy, 32'd0);
    chk("rst_frame_done", {31'b0, frame_done}, 32'd0);
    chk("rst_vad", {31'b0, vad}, 32'd0);
  endtask

  task automatic clear_model();
    fifo_q.delete();
    exp_mono.delete();
    rd_cyc.delete();
    exp_e.delete();
    exp_v.delete();
    e_acc = 0;
    m_cnt = 0;
    m_vad = 0;
    m_hang = 0;
    last_rd = -100;
  endtask

  initial begin
    int f0;
    int k;
    reset = 1'b1;
    fifo_data = '0;
    fifo_empty = 1'b1;
    enable = 1'b0;
    threshold = 32'd1000;
    repeat (3) @(negedge clk);
    #1;
    chk_outputs_zero();
    #1;
    reset = 1'b0;

    // Constant level
    run_frame(32'h0100_0100, 1'b1, "const_vad");
    chk("const_energy", frame_energy, 32'h0001_0000);
    chk("const_mono", {16'b0, mono_data}, 32'h0000_0100);

    // Hangover: four quiet frames keep vad, fifth drops it
    for (int i = 1; i <= 5; i++) run_frame(32'h0, i <= 4, "hang_vad");
    chk("quiet_energy", frame_energy, 32'd0);

    // Loud frame mid-hang reloads the hangover
    run_frame(32'h0100_0100, 1'b1, "reload_loud1");
    run_frame(32'h0, 1'b1, "reload_q1");
    run_frame(32'h0, 1'b1, "reload_q2");
    run_frame(32'h0100_0100, 1'b1, "reload_loud2");
    for (int i = 1; i <= 5; i++) run_frame(32'h0, i <= 4, "reload_hang");

    // Threshold boundary: equal is quiet, one below is loud
    threshold = 32'h0001_0000;
    run_frame(32'h0100_0100, 1'b0, "thr_equal");
    threshold = 32'h0000_FFFF;
    run_frame(32'h0100_0100, 1'b1, "thr_below");
    threshold = 32'd1000;

    // Extremes
    run_frame(32'h7FFF_8000, 1'b1, "ext_mix_vad");
    chk("ext_mix_mono", {16'b0, mono_data}, 32'h0000_FFFF);
    chk("ext_mix_energy", frame_energy, 32'd1);
    run_frame(32'h8000_8000, 1'b1, "ext_min_vad");
    chk("ext_min_mono", {16'b0, mono_data}, 32'h0000_8000);
    chk("ext_min_energy", frame_energy, 32'h4000_0000);

    // Random flow control and random data
    rand_mode = 1;
    threshold = $urandom;
    push_rand(2 * FRAME_LEN);
    wait_frames(frames_seen + 2, 12000);
    rand_mode = 0;
    chk("flow_drained", 32'(exp_mono.size()), 32'd0);

    // Reset in the ACC cycle of sample 100, then a full fresh frame
    threshold = 32'd1000;
    push_rand(300);
    mono_seen = 0;
    k = 0;
    while (!(mono_valid === 1'b1 && mono_seen == 100) && k < 3000) begin
      @(negedge clk);
      #2;
      k++;
    end
    chk("reach_sample100", {31'b0, mono_seen == 100}, 32'd1);
    reset = 1'b1;
    #1;
    chk_outputs_zero();
    clear_model();
    f0 = frames_seen;
    @(negedge clk);
    #2;
    reset = 1'b0;
    push_rand(FRAME_LEN);
    mono_seen = 0;
    k = 0;
    while (mono_seen < FRAME_LEN - 1 && k < 3000) begin
      @(negedge clk);
      #2;
      k++;
    end
    chk("no_early_frame", 32'(frames_seen), 32'(f0));
    wait_frames(f0 + 1, 2000);
    chk("post_rst_drained", 32'(exp_mono.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule

// File: doc/audio_vad_framer.md
# audio_vad_framer

Downstream consumer of the audio core's ADC sample FIFO, on the speech-recognition path. Pops packed stereo 32-bit samples through the FIFO read port and down-mixes each to signed 16-bit mono. Accumulates per-frame energy over fixed-length frames and produces a voice-activity flag with hangover. The mono stream and frame results feed the feature-extraction stage and a Nios-visible status register.

## Interface
Parameters:
- LOG2_FRAME, 8, log2 of samples per frame (FRAME_LEN = 2^LOG2_FRAME; legal 4..10)
- HANG_FRAMES, 4, quiet frames tolerated before vad drops (legal 0..15)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  permits new FIFO reads
- fifo_empty  in  1  ADC FIFO empty flag
- fifo_rd  out  1  one-cycle FIFO pop strobe
- fifo_data  in  32  sample, left [31:16], right [15:0], both signed; valid the cycle after fifo_rd
- threshold  in  32  unsigned energy threshold, sampled in DONE
- mono_data  out  16  signed down-mixed sample
- mono_valid  out  1  one-cycle strobe for mono_data
- frame_energy  out  32  mean-square energy of the last completed frame
- frame_done  out  1  one-cycle strobe, frame_energy/vad updated
- vad  out  1  voice-activity flag

## Operation
- FSM states: IDLE, RD, WAIT, ACC, DONE.
  - IDLE: if enable=1 and fifo_empty=0, go to RD; otherwise stay.
  - RD: fifo_rd=1 (Moore output); go to WAIT.
  - WAIT: capture fifo_data into the sample register; go to ACC.
  - ACC: present the mono sample and accumulate. If sample_cnt = FRAME_LEN-1, go to DONE; otherwise increment sample_cnt and go to IDLE.
  - DONE: update frame results; go to IDLE.
- Down-mix: mono = (sext17(L) + sext17(R)) >>> 1, taking bits [15:0]. The shift is arithmetic, so the result rounds toward -inf and cannot overflow.
- Energy: sq = mono*mono, 31-bit unsigned (max 2^30). acc is (31+LOG2_FRAME) bits unsigned and cannot overflow.
- In ACC: mono_data <= mono, mono_valid=1, acc <= acc + sq.
- In DONE:
  - frame_energy <= acc[LOG2_FRAME+31:LOG2_FRAME], zero-extended to 32 bits.
  - acc <= 0 and sample_cnt <= 0.
  - frame_done=1.
- VAD update in DONE, using energy E:
  - If E > threshold (strict): vad <= 1 and hang <= HANG_FRAMES.
  - Else if hang != 0: hang <= hang-1 and vad stays 1.
  - Else: vad <= 0.
- enable is checked only in IDLE. Deasserting it never aborts RD/WAIT/ACC/DONE. The partial frame (acc, sample_cnt) is retained and resumes on re-enable.
- fifo_empty is checked only in IDLE, so the block never pops an empty FIFO.
- Reset, asynchronous and at any point including mid-frame:
  - State returns to IDLE.
  - acc, sample_cnt, hang are 0.
  - All outputs are 0: fifo_rd, mono_data, mono_valid, frame_energy, frame_done, vad.
  - A partial frame is discarded.

## Timing
- IDLE condition true in cycle N-1 gives fifo_rd=1 in cycle N.
- fifo_data is valid in cycle N+1 and registered at the end of N+1.
- mono_valid/mono_data are asserted in cycle N+2.
- For the last sample of a frame, frame_done, frame_energy and vad change in cycle N+3.
- Minimum fifo_rd spacing: 4 cycles; 5 cycles across a frame boundary.
- fifo_rd, mono_valid and frame_done are exactly one cycle wide.
- mono_data, frame_energy and vad hold their values between updates.
- All outputs are registered except fifo_rd, which is decoded from the state register.

## Test plan
- Reset: assert reset mid-ACC of sample 100 -> all outputs 0 the same cycle. After release, frame_done appears only after 256 further samples.
- Constant level: 256 samples of L=R=0x0100, threshold=1000 -> mono_data=0x0100 every sample; frame_done once; frame_energy=0x00010000; vad=1.
- Extremes:
  - L=0x7FFF, R=0x8000 -> mono_data=0xFFFF.
  - A full frame of L=R=0x8000 -> mono_data=0x8000 and frame_energy=0x40000000, with no wrap.
- Hangover: one frame at 0x0100, then zero frames, HANG_FRAMES=4, threshold=1000 -> vad=1 through frame_done of quiet frames 1-4 and 0 at quiet frame 5. A loud frame mid-hang reloads hang.
- Flow control: random fifo_empty and enable toggling -> no fifo_rd while empty in IDLE; fifo_rd pulses at least 4 cycles apart. The mono_data sequence equals the scoreboard's down-mix of popped words with no loss or duplication.
- Threshold boundary: frame energy exactly equal to threshold -> treated as quiet (vad follows the hang path). Threshold one below -> vad=1.
